// File: rtl/ps2_held_key_decoder_if.sv
// Held-key status bundle from the PS/2 decoder to the keyboard-driven datapath.
interface ps2_held_key_decoder_if;
  logic [7:0] heldData;
  logic       heldExt;
  logic       codeValid;
  logic       frameErr;

  modport master (
    output heldData,
    output heldExt,
    output codeValid,
    output frameErr
  );

  modport slave (
    input heldData,
    input heldExt,
    input codeValid,
    input frameErr
  );
endinterface

// File: rtl/ps2_held_key_decoder.sv
// PS/2 receive front end: frame assembly plus make/break/E0 decode into a single "held key" byte.
// Optional parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_held_key_decoder #(
  parameter int CLOCK_FREQUENCY = 25000000,
  parameter int TIMEOUT_CYCLES  = CLOCK_FREQUENCY / 2000
) (
  input  logic Clock,
  input  logic reset,
  inout  wire  PS2_CLK,
  inout  wire  PS2_DAT,
  ps2_held_key_decoder_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_CHECK = 1'b1;
`else
  localparam bit PARITY_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_NORMAL,
    S_EXT,
    S_BREAK,
    S_EXT_BREAK
  } state_t;

  assign PS2_CLK = 1'bz;
  assign PS2_DAT = 1'bz;

  logic [2:0]    r_clkSync;
  logic [1:0]    r_datSync;
  logic [3:0]    r_bitCount;
  logic [8:0]    r_shift;
  logic [TW-1:0] r_timeout;
  logic          r_codeValid;
  logic          r_frameErr;
  state_t        r_state;
  logic [7:0]    r_heldData;
  logic          r_heldExt;

  logic          w_fall;
  logic          w_dat;
  logic          w_lastEdge;
  logic          w_stopOk;
  logic          w_parityOk;
  logic          w_accept;
  logic          w_drop;
  logic          w_timeoutHit;
  logic [7:0]    w_byte;
  logic          w_isIgnored;
  state_t        w_nextState;
  logic [7:0]    w_nextHeld;
  logic          w_nextExt;

  // Sync stages idle high so leaving reset never fakes a falling edge.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      r_clkSync <= 3'b111;
      r_datSync <= 2'b11;
    end else begin
      r_clkSync <= {r_clkSync[1:0], PS2_CLK};
      r_datSync <= {r_datSync[0], PS2_DAT};
    end
  end

  assign w_fall       = r_clkSync[2] & ~r_clkSync[1];
  assign w_dat        = r_datSync[1];
  assign w_byte       = r_shift[7:0];
  assign w_lastEdge   = w_fall && (r_bitCount == 4'd10);
  assign w_stopOk     = w_dat;
  assign w_parityOk   = (^r_shift) | ~PARITY_CHECK;
  assign w_accept     = w_lastEdge & w_stopOk & w_parityOk;
  assign w_drop       = w_lastEdge & ~(w_stopOk & w_parityOk);
  assign w_timeoutHit = (r_bitCount != 4'd0) && !w_fall &&
                        (r_timeout == TW'(TIMEOUT_CYCLES - 1));

  // Bit counter 0 = idle; 1..9 shift D0..D7 and parity; 10 = waiting for the stop bit.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      r_bitCount  <= 4'd0;
      r_shift     <= 9'd0;
      r_timeout   <= '0;
      r_codeValid <= 1'b0;
      r_frameErr  <= 1'b0;
    end else begin
      r_codeValid <= w_accept;
      r_frameErr  <= w_drop | w_timeoutHit;
      if (w_fall) begin
        r_timeout <= '0;
        if (r_bitCount == 4'd0) begin
          if (!w_dat) begin
            r_bitCount <= 4'd1;
          end
        end else if (r_bitCount == 4'd10) begin
          r_bitCount <= 4'd0;
        end else begin
          r_shift    <= {w_dat, r_shift[8:1]};
          r_bitCount <= r_bitCount + 4'd1;
        end
      end else if (r_bitCount != 4'd0) begin
        if (w_timeoutHit) begin
          r_bitCount <= 4'd0;
          r_timeout  <= '0;
        end else begin
          r_timeout <= r_timeout + 1'b1;
        end
      end
    end
  end

  assign w_isIgnored = w_byte inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  always_ff @(posedge Clock) begin
    if (!reset) begin
      r_state    <= S_NORMAL;
      r_heldData <= 8'h00;
      r_heldExt  <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_heldData <= w_nextHeld;
      r_heldExt  <= w_nextExt;
    end
  end

  // Last-pressed key wins; a break only clears when it names exactly the held key.
  always_comb begin
    w_nextState = r_state;
    w_nextHeld  = r_heldData;
    w_nextExt   = r_heldExt;
    if (w_accept) begin
      case (r_state)
        S_NORMAL: begin
          if (w_byte == 8'hE0) begin
            w_nextState = S_EXT;
          end else if (w_byte == 8'hF0) begin
            w_nextState = S_BREAK;
          end else if (!w_isIgnored) begin
            w_nextHeld = w_byte;
            w_nextExt  = 1'b0;
          end
        end
        S_EXT: begin
          if (w_byte == 8'hF0) begin
            w_nextState = S_EXT_BREAK;
          end else begin
            w_nextState = S_NORMAL;
            if (w_byte != 8'h12) begin
              w_nextHeld = w_byte;
              w_nextExt  = 1'b1;
            end
          end
        end
        S_BREAK: begin
          w_nextState = S_NORMAL;
          if ((w_byte == r_heldData) && !r_heldExt) begin
            w_nextHeld = 8'h00;
            w_nextExt  = 1'b0;
          end
        end
        S_EXT_BREAK: begin
          w_nextState = S_NORMAL;
          if ((w_byte == r_heldData) && r_heldExt) begin
            w_nextHeld = 8'h00;
            w_nextExt  = 1'b0;
          end
        end
        default: w_nextState = S_NORMAL;
      endcase
    end
  end

  assign bus.heldData  = r_heldData;
  assign bus.heldExt   = r_heldExt;
  assign bus.codeValid = r_codeValid;
  assign bus.frameErr  = r_frameErr;

endmodule

// File: doc/ps2_held_key_decoder.md
Name: ps2_held_key_decoder

Overview:
- PS/2 receive front end for the game controller; sits directly upstream of the keyboard-driven datapath.
- Samples the PS2_CLK/PS2_DAT lines, assembles 11-bit device-to-host frames, and decodes the make, break (F0) and extended (E0) scan-code sequences.
- Presents a level-style "currently held key" byte, heldData, which is 0x00 when no tracked key is held.
- The consumer compares heldData against codes such as 0x29 (space), 0x76 (Esc), 0x5A (Enter), 0x16 ('1') and 0x59 (R-shift).

Parameters:
- CLOCK_FREQUENCY, 25000000, system clock frequency in Hz.
- TIMEOUT_CYCLES, CLOCK_FREQUENCY/2000, maximum number of Clock cycles allowed between PS/2 falling edges within one frame (500 us).

Ports:
- Clock  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- PS2_CLK  inout  1  PS/2 clock line; never driven (constant high-Z).
- PS2_DAT  inout  1  PS/2 data line; never driven (constant high-Z).
- heldData  output  8  scan code of the held key; 0x00 when none is held.
- heldExt  output  1  1 when heldData came from an E0-prefixed sequence.
- codeValid  output  1  one-cycle pulse for each accepted frame byte.
- frameErr  output  1  one-cycle pulse when a frame is dropped (stop bit, parity or timeout).

Behaviour:
- Reset values, applied by synchronous active-low reset on Clock: heldData=0x00, heldExt=0, codeValid=0, frameErr=0, bit counter=0, timeout counter=0, decode state=S_NORMAL.
  - Reset asserted mid-frame discards the partial frame.
- Synchronisation: PS2_CLK and PS2_DAT each pass through 2 flip-flops. A third PS2_CLK stage is used for edge detection.
  - A falling edge is detected when the previous stage is 1 and the current stage is 0.
  - Data is sampled from the synchronised PS2_DAT in the cycle in which the falling edge is detected.
- Frame order: start(0), D0..D7 (LSB first), odd parity, stop(1), for 11 falling edges in total.
  - Start bit sampled as 1: the edge is ignored and the counter stays at 0. This resynchronises the receiver.
  - After the 11th edge, the frame is checked in the same cycle.
  - Stop bit 0 gives a frameErr pulse on the next cycle and the byte is discarded.
  - On a good frame, codeValid pulses on the next cycle and the decode FSM consumes the byte on that same edge.
- Timeout: the counter is cleared on every falling edge and increments while the bit counter is nonzero.
  - Reaching TIMEOUT_CYCLES: bit counter returns to 0, frameErr pulses for 1 cycle, and the byte is discarded.
  - The timeout counter does not run while idle (bit counter = 0).
- Decode FSM, which steps on accepted bytes only:
  - S_NORMAL:
    - 0xE0 goes to S_EXT.
    - 0xF0 goes to S_BREAK.
    - 0xAA, 0xFA, 0xEE, 0xFE, 0x00 and 0xFF are ignored and the state stays S_NORMAL.
    - Any other byte is a make code: heldData=byte, heldExt=0.
  - S_EXT:
    - 0xF0 goes to S_EXT_BREAK.
    - 0x12 (fake shift) is ignored and returns to S_NORMAL.
    - Any other byte is a make code: heldData=byte, heldExt=1, then S_NORMAL.
  - S_BREAK: if byte==heldData and heldExt==0, clear heldData to 0x00 and heldExt to 0. Always return to S_NORMAL.
  - S_EXT_BREAK: same as S_BREAK but matches heldExt==1.
- Held-key rules:
  - Typematic repeat of the held key: no change; the codeValid pulse still occurs.
  - Make of a new key while another is held: heldData takes the newer key (last-pressed wins).
  - Break of the newer key: heldData becomes 0x00; it does not revert to the older key.
  - Break of a non-held key: no change.
- heldData and heldExt update on the same Clock edge, at most 2 cycles after the 11th edge of the final byte is detected.
- The lines are never driven: PS2_CLK and PS2_DAT are constant 1'bz, and host-to-device transmit is out of scope.

Optional Feature:
- Macro PS2_PARITY_CHECK_EN.
- Defined: the odd parity over D0..D7 plus the parity bit is checked. A mismatch gives a frameErr pulse and the byte is discarded; the decode FSM state is unchanged.
- Undefined: the parity bit is sampled but ignored, and only the stop bit and timeout raise frameErr.

Test Plan:
- Frames 0x29, then 0xF0, 0x29 at a 12.5 kHz PS/2 clock -> heldData=0x29 within 2 cycles of the first frame's 11th edge; after the 0x29 break frame, heldData=0x00; three codeValid pulses; frameErr never asserts.
- Frames 0x76, 0x5A, 0xF0 0x5A, 0xF0 0x76 -> heldData sequence 0x76, 0x5A, 0x00, 0x00; the final break causes no change.
- Frames 0xE0 0x75, then 0xE0 0xF0 0x75 -> heldData=0x75 with heldExt=1, then 0x00 with heldExt=0. A non-extended 0xF0 0x75 sent while the extended key is held causes no change.
- Frame with data 0x29 and wrong parity -> with PS2_PARITY_CHECK_EN: one frameErr pulse and heldData stays 0x00; without it: heldData=0x29.
- 5 edges of a frame, then idle for TIMEOUT_CYCLES -> one frameErr pulse; a following good frame 0x16 gives heldData=0x16.
- reset low for 1 cycle after the 6th edge of a frame -> all outputs at reset values; the next complete 0x59 frame gives heldData=0x59.
